id_ex_fwd_reg: RTL

ID/EX pipeline register for the 5-stage MIPS pipeline, sitting directly upstream of the EX-stage forwarding muxes (ForwardA, and ForwardB merged with ALUSrc). Captures decode-stage operands and control, applies stall, flush and load-use bubbles, and precomputes the 2-bit ForwardA/ForwardB selects one cycle early so EX sees registered selects. Also bypasses the same-cycle WB write into captured operands and raises the load-use hazard flag to the IF/ID front end.

---
 rtl/id_ex_fwd_reg_pkg.sv | 34 +++
 rtl/id_ex_fwd_reg_fwd_sel.sv | 23 ++
 rtl/id_ex_fwd_reg.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/id_ex_fwd_reg_pkg.sv
// Shared types for the ID/EX register: forward codes,
// control bundle and the producer-match helper.
package id_ex_fwd_reg_pkg;

  localparam int XLEN    = 32;
  localparam int RIDX    = 5;
  localparam int ALUOP_W = 2;

  typedef logic [1:0] fwd_t;

  localparam fwd_t FWD_NONE = 2'b00;
  localparam fwd_t FWD_MEM  = 2'b10;
  localparam fwd_t FWD_WB   = 2'b11;

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic               branch;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  // $0 is never a real producer
  function automatic logic prod_hit(
    input logic            we,
    input logic [RIDX-1:0] dst,
    input logic [RIDX-1:0] src
  );
    return we && (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/id_ex_fwd_reg_fwd_sel.sv
// Forward select for one source register;
// the nearer producer (now in EX) wins.
module fwd_sel
  import id_ex_fwd_reg_pkg::*;
(
  input  logic [RIDX-1:0] src_i,
  input  logic            ex_we_i,
  input  logic [RIDX-1:0] ex_dst_i,
  input  logic            mem_we_i,
  input  logic [RIDX-1:0] mem_dst_i,
  output fwd_t            fwd_o
);

  always_comb begin
    fwd_o = FWD_NONE;
    if (prod_hit(ex_we_i, ex_dst_i, src_i)) begin
      fwd_o = FWD_MEM;
    end else if (prod_hit(mem_we_i, mem_dst_i, src_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_fwd_reg.sv
// ID/EX pipeline register with early forward selects,
// WB bypass and load-use detection.
module id_ex_fwd_reg
  import id_ex_fwd_reg_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [XLEN-1:0]    ID_ReadData1,
  input  logic [XLEN-1:0]    ID_ReadData2,
  input  logic [XLEN-1:0]    ID_SignExt,
  input  logic [RIDX-1:0]    ID_Rs,
  input  logic [RIDX-1:0]    ID_Rt,
  input  logic [RIDX-1:0]    ID_Rd,
  input  logic               ID_RegWrite,
  input  logic               ID_MemtoReg,
  input  logic               ID_MemRead,
  input  logic               ID_MemWrite,
  input  logic               ID_Branch,
  input  logic               ID_RegDst,
  input  logic               ID_ALUSrc,
  input  logic [ALUOP_W-1:0] ID_ALUOp,
  input  logic               MEM_RegWrite,
  input  logic [RIDX-1:0]    MEM_WriteReg,
  input  logic               WB_RegWrite,
  input  logic [RIDX-1:0]    WB_WriteReg,
  input  logic [XLEN-1:0]    WB_WriteData,
  output logic [XLEN-1:0]    EX_ReadData1,
  output logic [XLEN-1:0]    EX_ReadData2,
  output logic [XLEN-1:0]    EX_SignExt,
  output logic               EX_RegWrite,
  output logic               EX_MemtoReg,
  output logic               EX_MemRead,
  output logic               EX_MemWrite,
  output logic               EX_Branch,
  output logic               EX_ALUSrc,
  output logic [ALUOP_W-1:0] EX_ALUOp,
  output logic [RIDX-1:0]    EX_WriteReg,
  output logic [1:0]         EX_ForwardA,
  output logic [1:0]         EX_ForwardB,
  output logic               load_use_hazard
);

  ctrl_t           ctrl_q, ctrl_d, id_ctrl;
  logic [RIDX-1:0] wreg_q, wreg_d, id_wreg;
  logic [XLEN-1:0] rd1_q, rd1_d;
  logic [XLEN-1:0] rd2_q, rd2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  fwd_t            fa_q, fa_d;
  fwd_t            fb_q, fb_d;
  fwd_t            fa_raw, fb_raw;
  logic            b_is_imm;
  logic [XLEN-1:0] id_rd1, id_rd2;

  assign id_ctrl = '{
    reg_write:  ID_RegWrite,
    mem_to_reg: ID_MemtoReg,
    mem_read:   ID_MemRead,
    mem_write:  ID_MemWrite,
    branch:     ID_Branch,
    alu_src:    ID_ALUSrc,
    alu_op:     ID_ALUOp
  };

  assign id_wreg  = ID_RegDst ? ID_Rd : ID_Rt;
  assign b_is_imm = ID_ALUSrc && !ID_MemWrite;

  assign load_use_hazard =
    ctrl_q.mem_read && (wreg_q != '0) &&
    ((wreg_q == ID_Rs) ||
     ((wreg_q == ID_Rt) && !b_is_imm));

  fwd_sel u_sel_a (
    .src_i     (ID_Rs),
    .ex_we_i   (ctrl_q.reg_write),
    .ex_dst_i  (wreg_q),
    .mem_we_i  (MEM_RegWrite),
    .mem_dst_i (MEM_WriteReg),
    .fwd_o     (fa_raw)
  );

  fwd_sel u_sel_b (
    .src_i     (ID_Rt),
    .ex_we_i   (ctrl_q.reg_write),
    .ex_dst_i  (wreg_q),
    .mem_we_i  (MEM_RegWrite),
    .mem_dst_i (MEM_WriteReg),
    .fwd_o     (fb_raw)
  );

  // register file reads miss the same-cycle WB write
  assign id_rd1 = prod_hit(WB_RegWrite, WB_WriteReg, ID_Rs)
                ? WB_WriteData : ID_ReadData1;
  assign id_rd2 = prod_hit(WB_RegWrite, WB_WriteReg, ID_Rt)
                ? WB_WriteData : ID_ReadData2;

  always_comb begin
    ctrl_d = ctrl_q;
    wreg_d = wreg_q;
    rd1_d  = rd1_q;
    rd2_d  = rd2_q;
    imm_d  = imm_q;
    fa_d   = fa_q;
    fb_d   = fb_q;
    if (stall) begin
      ctrl_d = ctrl_q;
    end else if (flush || load_use_hazard) begin
      ctrl_d = '0;
      wreg_d = '0;
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      fa_d   = FWD_NONE;
      fb_d   = FWD_NONE;
    end else begin
      ctrl_d = id_ctrl;
      wreg_d = id_wreg;
      rd1_d  = id_rd1;
      rd2_d  = id_rd2;
      imm_d  = ID_SignExt;
      fa_d   = fa_raw;
      fb_d   = b_is_imm ? FWD_NONE : fb_raw;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl_q <= '0;
      wreg_q <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      fa_q   <= FWD_NONE;
      fb_q   <= FWD_NONE;
    end else begin
      ctrl_q <= ctrl_d;
      wreg_q <= wreg_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      fa_q   <= fa_d;
      fb_q   <= fb_d;
    end
  end

  assign EX_ReadData1 = rd1_q;
  assign EX_ReadData2 = rd2_q;
  assign EX_SignExt   = imm_q;
  assign EX_RegWrite  = ctrl_q.reg_write;
  assign EX_MemtoReg  = ctrl_q.mem_to_reg;
  assign EX_MemRead   = ctrl_q.mem_read;
  assign EX_MemWrite  = ctrl_q.mem_write;
  assign EX_Branch    = ctrl_q.branch;
  assign EX_ALUSrc    = ctrl_q.alu_src;
  assign EX_ALUOp     = ctrl_q.alu_op;
  assign EX_WriteReg  = wreg_q;
  assign EX_ForwardA  = fa_q;
  assign EX_ForwardB  = fb_q;

endmodule
